// File: rtl/bus_master_if.sv
// bus_master_if: single-outstanding request master that converts client
// byte/HW/FW/DW requests into one or two 32-bit slave transfers, with
// alignment checking, per-phase wait timeout and registered outputs.
module bus_master_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic [31:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [63:0] o_resp_rdata,
  output logic [31:0] o_bus_addr,
  output logic [8:0]  o_bus_control,
  output logic [31:0] o_bus_data_out,
  input  logic [31:0] i_bus_data_in,
  output logic        o_bus_en,
  input  logic        i_bus_ready
);

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned BUS_W    = 32;
  localparam int unsigned CTRL_W   = 9;
  localparam int unsigned CTRL_PAD = CTRL_W - 3;
  localparam int unsigned WAIT_W   = 8;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_HW = 2'b01;
  localparam logic [1:0] SZ_FW = 2'b10;
  localparam logic [1:0] SZ_DW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Lanes that carry valid data for a given transfer size
  function automatic logic [BUS_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = BUS_W'(32'h0000_00FF);
      SZ_HW:   size_mask = BUS_W'(32'h0000_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  // Natural-alignment check on the low address bits
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      SZ_HW:   misaligned = addr_lo[0];
      SZ_FW:   misaligned = |addr_lo[1:0];
      SZ_DW:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Control and latched-request state
  state_t              r_state;
  logic                r_beat;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_write;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  // Registered outputs
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [CTRL_W-1:0]   r_bus_control;
  logic [BUS_W-1:0]    r_bus_data_out;
  logic                r_bus_en;

  // Next-state values
  state_t              w_state_nxt;
  logic                w_beat_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                w_write_nxt;
  logic [1:0]          w_size_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_err_nxt;
  logic [BUS_W-1:0]    w_cap;
  logic [1:0]          w_bus_size;
  logic [BUS_W-1:0]    w_half;

  // Next-output values
  logic                w_req_ready_nxt;
  logic                w_resp_valid_nxt;
  logic                w_resp_err_nxt;
  logic [DATA_W-1:0]   w_resp_rdata_nxt;
  logic [ADDR_W-1:0]   w_bus_addr_nxt;
  logic [CTRL_W-1:0]   w_bus_control_nxt;
  logic [BUS_W-1:0]    w_bus_data_out_nxt;
  logic                w_bus_en_nxt;

  // Next-state logic plus output values derived from the state being entered
  always_comb begin
    w_state_nxt        = r_state;
    w_beat_nxt         = r_beat;
    w_wait_nxt         = r_wait;
    w_write_nxt        = r_write;
    w_size_nxt         = r_size;
    w_addr_nxt         = r_addr;
    w_wdata_nxt        = r_wdata;
    w_rdata_nxt        = r_rdata;
    w_err_nxt          = 1'b0;
    w_cap              = i_bus_data_in & size_mask(r_size);
    w_bus_size         = 2'b00;
    w_half             = '0;
    w_req_ready_nxt    = 1'b0;
    w_resp_valid_nxt   = 1'b0;
    w_resp_err_nxt     = 1'b0;
    w_resp_rdata_nxt   = '0;
    w_bus_addr_nxt     = '0;
    w_bus_control_nxt  = '0;
    w_bus_data_out_nxt = '0;
    w_bus_en_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_req_valid && r_req_ready) begin
          w_write_nxt = i_req_write;
          w_size_nxt  = i_req_size;
          w_addr_nxt  = i_req_addr;
          w_wdata_nxt = i_req_wdata;
          w_rdata_nxt = '0;
          w_beat_nxt  = 1'b0;
          w_wait_nxt  = '0;
          if (misaligned(i_req_size, i_req_addr[2:0])) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (i_bus_ready) begin
          w_state_nxt = ST_DATA;
          w_wait_nxt  = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b1;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_DATA: begin
        if (i_bus_ready) begin
          if (!r_write) begin
            if (r_beat) w_rdata_nxt[63:32] = w_cap;
            else        w_rdata_nxt[31:0]  = w_cap;
          end
          if ((r_size == SZ_DW) && !r_beat) begin
            w_state_nxt = ST_ADDR;
            w_beat_nxt  = 1'b1;
            w_wait_nxt  = '0;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b1;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_req_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_resp_valid_nxt = (w_state_nxt == ST_RESP);
    w_resp_err_nxt   = w_err_nxt;
    if ((w_state_nxt == ST_RESP) && !w_err_nxt && !w_write_nxt) begin
      w_resp_rdata_nxt = w_rdata_nxt;
    end

    // DW goes out as two FW beats
    w_bus_size = (w_size_nxt == SZ_DW) ? SZ_FW : w_size_nxt;
    w_half     = w_beat_nxt ? w_wdata_nxt[63:32] : w_wdata_nxt[31:0];
    if ((w_state_nxt == ST_ADDR) || (w_state_nxt == ST_DATA)) begin
      w_bus_en_nxt      = 1'b1;
      w_bus_addr_nxt    = w_addr_nxt + (w_beat_nxt ? ADDR_W'(4) : ADDR_W'(0));
      w_bus_control_nxt = {CTRL_PAD'(0), w_bus_size, w_write_nxt};
    end
    if ((w_state_nxt == ST_DATA) && w_write_nxt) begin
      w_bus_data_out_nxt = w_half & size_mask(w_size_nxt);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= ST_IDLE;
      r_beat         <= 1'b0;
      r_wait         <= '0;
      r_write        <= 1'b0;
      r_size         <= 2'b00;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rdata        <= '0;
      r_req_ready    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_err     <= 1'b0;
      r_resp_rdata   <= '0;
      r_bus_addr     <= '0;
      r_bus_control  <= '0;
      r_bus_data_out <= '0;
      r_bus_en       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat         <= w_beat_nxt;
      r_wait         <= w_wait_nxt;
      r_write        <= w_write_nxt;
      r_size         <= w_size_nxt;
      r_addr         <= w_addr_nxt;
      r_wdata        <= w_wdata_nxt;
      r_rdata        <= w_rdata_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_resp_err     <= w_resp_err_nxt;
      r_resp_rdata   <= w_resp_rdata_nxt;
      r_bus_addr     <= w_bus_addr_nxt;
      r_bus_control  <= w_bus_control_nxt;
      r_bus_data_out <= w_bus_data_out_nxt;
      r_bus_en       <= w_bus_en_nxt;
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_err     = r_resp_err;
  assign o_resp_rdata   = r_resp_rdata;
  assign o_bus_addr     = r_bus_addr;
  assign o_bus_control  = r_bus_control;
  assign o_bus_data_out = r_bus_data_out;
  assign o_bus_en       = r_bus_en;

endmodule

// File: tb/tb_bus_master_if.sv
// Testbench for bus_master_if: directed vector table, hand-written reset and
// timeout sequences, and randomized transactions checked against a
// phase-list reference model.
module tb_bus_master_if;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic [31:0] bus_addr;
  logic [8:0]  bus_control;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;
  logic        bus_en;
  logic        bus_ready;

  // Slave data source: base address returns d0, the +4 beat returns d1
  logic [31:0] cur_addr;
  logic [31:0] cur_d0;
  logic [31:0] cur_d1;
  assign bus_data_in = (bus_addr == cur_addr) ? cur_d0 : cur_d1;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the last do_txn call
  int          res_lat;
  logic        res_err;
  logic [63:0] res_rd;
  logic [8:0]  res_ctl;
  logic [31:0] res_dout0;
  logic [31:0] res_dout1;

  bus_master_if #(.TIMEOUT(TMO)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_size     (req_size),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_err     (resp_err),
    .o_resp_rdata   (resp_rdata),
    .o_bus_addr     (bus_addr),
    .o_bus_control  (bus_control),
    .o_bus_data_out (bus_data_out),
    .i_bus_data_in  (bus_data_in),
    .o_bus_en       (bus_en),
    .i_bus_ready    (bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int pct, input int stall_ph, input int ph);
    if (ph == stall_ph) return 1'b0;
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] sz);
    if (sz >= 2'd2) return 32'hFFFF_FFFF;
    return (32'd1 << (8 << sz)) - 32'd1;
  endfunction

  task automatic check_bus_idle(input string tag);
    chk({tag, "_bus_en"},   64'(bus_en), 64'd0);
    chk({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
    chk({tag, "_bus_ctrl"}, 64'(bus_control), 64'd0);
    chk({tag, "_bus_dout"}, 64'(bus_data_out), 64'd0);
  endtask

  // One full transaction. The model walks a list of bus phases
  // (ADDR,DATA[,ADDR,DATA]) and counts consecutive not-ready cycles per phase.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [63:0] wd, input logic [31:0] d0, input logic [31:0] d1,
                        input int pct, input int stall_ph);
    int nph;
    int ph;
    int lows;
    int guard;
    bit done;
    bit finished;
    bit en_seen;
    logic r;
    logic m_err;
    logic [63:0] m_rd;
    logic [31:0] msk;
    logic [31:0] half;
    logic [1:0]  bsz;

    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_ready", 64'(req_ready), 64'd1);

    cur_addr  = a;
    cur_d0    = d0;
    cur_d1    = d1;
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    bus_ready = 1'b1;

    msk      = lane_mask(sz);
    bsz      = (sz == 2'd3) ? 2'd2 : sz;
    m_err    = 1'b0;
    m_rd     = '0;
    ph       = 0;
    lows     = 0;
    finished = 1'b0;
    en_seen  = 1'b0;
    res_ctl  = '0;
    res_dout0 = '0;
    res_dout1 = '0;
    res_lat  = 0;
    if ((a % (32'd1 << sz)) != 32'd0) begin
      done = 1'b1; m_err = 1'b1; nph = 0;
    end else begin
      done = 1'b0; nph = (sz == 2'd3) ? 4 : 2;
    end

    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (done) begin
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("resp_err",   64'(resp_err), 64'(m_err));
        chk("resp_rdata", resp_rdata, (m_err || w) ? 64'd0 : m_rd);
        chk("resp_ready", 64'(req_ready), 64'd0);
        check_bus_idle("resp");
        res_lat   = cyc;
        res_err   = resp_err;
        res_rd    = resp_rdata;
        req_valid = 1'b0;
        finished  = 1'b1;
        break;
      end
      chk("busy_resp_valid", 64'(resp_valid), 64'd0);
      chk("busy_req_ready",  64'(req_ready), 64'd0);
      chk("bus_en",   64'(bus_en), 64'd1);
      chk("bus_addr", 64'(bus_addr), 64'(a + ((ph >= 2) ? 32'd4 : 32'd0)));
      chk("bus_ctrl", 64'(bus_control), 64'({6'd0, bsz, w}));
      if (!en_seen) begin
        res_ctl = bus_control;
        en_seen = 1'b1;
      end
      if ((ph % 2 == 1) && w) begin
        half = (ph == 3) ? wd[63:32] : wd[31:0];
        chk("bus_dout", 64'(bus_data_out), 64'(half & msk));
        if (ph == 1) res_dout0 = bus_data_out;
        else         res_dout1 = bus_data_out;
      end
      r = pick(pct, stall_ph, ph);
      bus_ready = r;
      if (pct < 100) begin
        req_valid = 1'(($urandom() & 32'd1));
        req_write = 1'($urandom() & 32'd1);
        req_size  = 2'($urandom() & 32'd3);
        req_addr  = $urandom();
        req_wdata = {$urandom(), $urandom()};
      end
      if (r) begin
        if ((ph % 2 == 1) && !w) begin
          if (ph == 3) m_rd[63:32] = d1 & msk;
          else         m_rd[31:0]  = d0 & msk;
        end
        ph++;
        lows = 0;
        if (ph == nph) done = 1'b1;
      end else begin
        lows++;
        if (lows == TMO) begin
          done  = 1'b1;
          m_err = 1'b1;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!finished) chk("txn_no_response", 64'd0, 64'd1);

    @(posedge clk);
    @(negedge clk);
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
    chk("post_req_ready",  64'(req_ready), 64'd1);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [63:0] wd;
    logic [31:0] d0;
    logic [31:0] d1;
    int          lat;
    logic        err;
    logic [63:0] rd;
    logic [8:0]  ctl;
    logic [31:0] dout0;
    logic [31:0] dout1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'd0;
    req_addr  = '0;
    req_wdata = '0;
    bus_ready = 1'b0;
    cur_addr  = '0;
    cur_d0    = '0;
    cur_d1    = '0;

    tbl[0]  = '{1'b1, 2'd2, 32'h0000_0010, 64'h0000_0000_DEAD_BEEF, 32'h0, 32'h0,
                3, 1'b0, 64'h0, 9'h005, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 32'h0000_0013, 64'h0, 32'hAABB_CC5A, 32'h0,
                3, 1'b0, 64'h0000_0000_0000_005A, 9'h000, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 2'd3, 32'h0000_0020, 64'h0, 32'h1111_1111, 32'h2222_2222,
                5, 1'b0, 64'h2222_2222_1111_1111, 9'h004, 32'h0, 32'h0};
    tbl[3]  = '{1'b1, 2'd1, 32'h0000_0003, 64'h1234, 32'h0, 32'h0,
                1, 1'b1, 64'h0, 9'h000, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 2'd1, 32'h0000_0006, 64'h0, 32'h1234_5678, 32'h0,
                3, 1'b0, 64'h0000_0000_0000_5678, 9'h002, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 2'd0, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFA5, 32'h0, 32'h0,
                3, 1'b0, 64'h0, 9'h001, 32'h0000_00A5, 32'h0};
    tbl[6]  = '{1'b1, 2'd3, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 32'h0, 32'h0,
                5, 1'b0, 64'h0, 9'h005, 32'h89AB_CDEF, 32'h0123_4567};
    tbl[7]  = '{1'b0, 2'd2, 32'h0000_0002, 64'h0, 32'h5555_5555, 32'h0,
                1, 1'b1, 64'h0, 9'h000, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 2'd3, 32'h0000_0004, 64'h0, 32'h5555_5555, 32'h0,
                1, 1'b1, 64'h0, 9'h000, 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 2'd3, 32'hFFFF_FFF8, 64'h0, 32'hCAFE_F00D, 32'h0BAD_BEEF,
                5, 1'b0, 64'h0BAD_BEEF_CAFE_F00D, 9'h004, 32'h0, 32'h0};
    tbl[10] = '{1'b1, 2'd1, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_BEEF, 32'h0, 32'h0,
                3, 1'b0, 64'h0, 9'h003, 32'h0000_BEEF, 32'h0};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err",   64'(resp_err), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    check_bus_idle("rst");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_release_ready", 64'(req_ready), 64'd1);

    // Directed vectors with the slave always ready
    foreach (tbl[i]) begin
      do_txn(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].d0, tbl[i].d1, 100, -1);
      chk($sformatf("vec%0d_latency", i), 64'(res_lat), 64'(tbl[i].lat));
      chk($sformatf("vec%0d_err", i),     64'(res_err), 64'(tbl[i].err));
      chk($sformatf("vec%0d_rdata", i),   res_rd, tbl[i].rd);
      chk($sformatf("vec%0d_ctrl", i),    64'(res_ctl), 64'(tbl[i].ctl));
      chk($sformatf("vec%0d_dout0", i),   64'(res_dout0), 64'(tbl[i].dout0));
      chk($sformatf("vec%0d_dout1", i),   64'(res_dout1), 64'(tbl[i].dout1));
    end

    // FW read stalled in DATA: 16 not-ready edges then error response
    do_txn(1'b0, 2'd2, 32'h0000_0100, 64'h0, 32'h7777_7777, 32'h0, 100, 1);
    chk("tmo_data_latency", 64'(res_lat), 64'(2 + TMO));
    chk("tmo_data_err",     64'(res_err), 64'd1);
    chk("tmo_data_rdata",   res_rd, 64'd0);

    // FW write stalled in ADDR
    do_txn(1'b1, 2'd2, 32'h0000_0104, 64'h1, 32'h0, 32'h0, 100, 0);
    chk("tmo_addr_latency", 64'(res_lat), 64'(1 + TMO));
    chk("tmo_addr_err",     64'(res_err), 64'd1);

    // DW read stalled in second DATA: first-beat data must be discarded
    do_txn(1'b0, 2'd3, 32'h0000_0108, 64'h0, 32'h3333_3333, 32'h4444_4444, 100, 3);
    chk("tmo_dw_latency", 64'(res_lat), 64'(4 + TMO));
    chk("tmo_dw_err",     64'(res_err), 64'd1);
    chk("tmo_dw_rdata",   res_rd, 64'd0);

    // Reset during DW beat1 DATA aborts silently
    @(negedge clk);
    cur_addr  = 32'h0000_0040;
    cur_d0    = 32'h9999_9999;
    cur_d1    = 32'h8888_8888;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd3;
    req_addr  = 32'h0000_0040;
    bus_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_pre_en",   64'(bus_en), 64'd1);
    chk("abort_pre_addr", 64'(bus_addr), 64'h44);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_bus_idle("abort");
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_req_ready",  64'(req_ready), 64'd0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_resp", 64'(resp_valid), 64'd0);
    end
    do_txn(1'b0, 2'd2, 32'h0000_0200, 64'h0, 32'h600D_CAFE, 32'h0, 100, -1);
    chk("after_abort_latency", 64'(res_lat), 64'd3);
    chk("after_abort_err",     64'(res_err), 64'd0);
    chk("after_abort_rdata",   res_rd, 64'h0000_0000_600D_CAFE);

    // Randomized transactions: mostly-ready slave, then a slow slave
    for (int k = 0; k < 260; k++) begin
      logic [31:0] ra;
      ra = $urandom();
      if (($urandom() & 32'd1) != 0) ra[2:0] = 3'd0;
      do_txn(1'($urandom() & 32'd1), 2'($urandom() & 32'd3), ra,
             {$urandom(), $urandom()}, $urandom(), $urandom(),
             (k < 200) ? 80 : 12, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
